// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: icache controller with a multi-beat line refill engine and kill drain
module icache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int MEM_DW = 32,
    parameter int BEATS = 4,
    localparam int LINE_W = MEM_DW * BEATS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if2icache_req_i,
    input  logic              if2icache_req_kill_i,
    input  logic [ADDR_W-1:0] if2icache_addr_i,
    input  logic              imem_sel_i,
    output logic              icache2if_ack_o,
    input  logic              cache_hit_i,
    output logic              cache_wr_o,
    output logic [ADDR_W-1:0] cache_wr_addr_o,
    output logic [LINE_W-1:0] cache_wr_line_o,
    output logic              icache2mem_req_o,
    output logic [ADDR_W-1:0] icache2mem_addr_o,
    input  logic [MEM_DW-1:0] mem2icache_data_i,
    input  logic              mem2icache_ack_i,
    output logic              refill_busy_o
);
    localparam int BYTES = MEM_DW / 8;
    localparam int OFF_W = $clog2(BEATS * BYTES);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0] line_buf;
    logic              ack;
    logic              kill;
    logic              lookup;

    assign kill = if2icache_req_kill_i | ~imem_sel_i;
    assign lookup = if2icache_req_i & imem_sel_i & ~if2icache_req_kill_i;

    // All outputs come straight from registered state
    always_comb begin
        icache2if_ack_o = ack;
        cache_wr_o = state == WRITE;
        cache_wr_addr_o = line_addr;
        cache_wr_line_o = line_buf;
        icache2mem_req_o = (state == REFILL) || (state == DRAIN);
        icache2mem_addr_o = line_addr + ADDR_W'(cnt) * ADDR_W'(BYTES);
        refill_busy_o = state != IDLE;
    end

    // Hit ack, refill sequencing and line assembly; a kill without a beat ack parks in DRAIN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            line_addr <= '0;
            line_buf <= '0;
            ack <= 1'b0;
        end else begin
            ack <= (state == IDLE) && lookup && cache_hit_i;
            case (state)
                IDLE: if (lookup && !cache_hit_i) begin
                    line_addr <= if2icache_addr_i & ~OFF_MASK;
                    cnt <= '0;
                    state <= REFILL;
                end
                REFILL: if (mem2icache_ack_i) begin
                    line_buf[cnt*MEM_DW +: MEM_DW] <= mem2icache_data_i;
                    cnt <= cnt + 1'b1;
                    state <= kill ? IDLE : (cnt == LAST) ? WRITE : REFILL;
                end else if (kill) begin
                    state <= DRAIN;
                end
                WRITE: state <= IDLE;
                DRAIN: if (mem2icache_ack_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
